biu_bus_arbiter: RTL and testbench

- Shares the single accelerator memory read port between the bus interface units: weight BIU, input-feature BIU and output/aux BIU.
- Each BIU holds a lock (req) for the length of its burst. The arbiter grants the bus to one BIU at a time and forwards that BIU's address handshakes to memory.
- Read responses come back in order and are routed to the BIU that issued them, using an ID FIFO. A BIU may release the bus while its responses are still in flight.

---
 rtl/biu_bus_arbiter.sv | 163 ++++++++++++++++
 tb/tb_biu_bus_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/biu_bus_arbiter.sv
// Shares one memory read port between the BIUs: lock-based grant, address forwarding, in-order response routing via an owner-ID FIFO.
// Optional build macro BIU_ARB_FIXED_PRIO_EN: fixed lowest-index-first priority instead of round-robin.
module biu_bus_arbiter #(
  parameter int NUM_REQ   = 3,
  parameter int OST_DEPTH = 8,
  parameter int AW        = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_lock,
  input  logic [NUM_REQ-1:0]         req_vld,
  input  logic [NUM_REQ*AW-1:0]      req_addr,
  output logic [NUM_REQ-1:0]         req_rdy,
  output logic [NUM_REQ-1:0]         rsp_vld,
  input  logic [NUM_REQ-1:0]         rsp_rdy,
  output logic [AW-1:0]              rsp_addr,
  output logic [AW-1:0]              rsp_data,
  output logic                       mem_vld,
  input  logic                       mem_rdy,
  output logic [AW-1:0]              mem_addr,
  input  logic                       mem_rsp_vld,
  output logic                       mem_rsp_rdy,
  input  logic [AW-1:0]              mem_rsp_addr,
  input  logic [AW-1:0]              mem_rsp_data,
  output logic [$clog2(NUM_REQ)-1:0] owner,
  output logic                       busy
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int PW = $clog2(OST_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] winner, cand;
  logic          found;
  logic [IW-1:0] id_fifo_q [OST_DEPTH];
  logic [IW-1:0] id_fifo_d [OST_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          fifo_full, fifo_empty, push, pop;
  logic [IW-1:0] head;

`ifndef BIU_ARB_FIXED_PRIO_EN
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
`endif

  // Winner search: first locked requester scanning upward (from rr_ptr with wrap, or from 0).
  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
`ifdef BIU_ARB_FIXED_PRIO_EN
      cand = IW'(i);
`else
      cand = IW'((int'(rr_ptr_q) + i) % NUM_REQ);
`endif
      if (!found && req_lock[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
`ifndef BIU_ARB_FIXED_PRIO_EN
    rr_ptr_d = rr_ptr_q;
`endif
    mem_vld = 1'b0;
    req_rdy = '0;
    case (state_q)
      IDLE: begin
        if (found) begin
          owner_d = winner;
`ifndef BIU_ARB_FIXED_PRIO_EN
          rr_ptr_d = (winner == IW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
`endif
          state_d = GRANT;
        end
      end
      GRANT: begin
        // A release cycle forwards nothing; the lock gate below covers that.
        if (!req_lock[owner_q]) begin
          state_d = IDLE;
        end else begin
          mem_vld          = req_vld[owner_q] & ~fifo_full;
          req_rdy[owner_q] = mem_rdy & ~fifo_full;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_addr   = req_addr[int'(owner_q)*AW +: AW];
  assign fifo_full  = (count_q == CW'(OST_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign push       = mem_vld & mem_rdy;
  assign head       = id_fifo_q[rd_ptr_q];

  // Response routing is independent of the grant so responses drain under any owner.
  always_comb begin
    rsp_vld       = '0;
    rsp_vld[head] = mem_rsp_vld & ~fifo_empty;
    mem_rsp_rdy   = rsp_rdy[head] & ~fifo_empty;
  end

  assign pop      = mem_rsp_vld & mem_rsp_rdy;
  assign rsp_addr = mem_rsp_addr;
  assign rsp_data = mem_rsp_data;
  assign owner    = owner_q;
  assign busy     = (state_q == GRANT) | ~fifo_empty;

  always_comb begin
    id_fifo_d = id_fifo_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (push) begin
      id_fifo_d[wr_ptr_q] = owner_q;
      wr_ptr_d            = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= '0;
`ifndef BIU_ARB_FIXED_PRIO_EN
      rr_ptr_q <= '0;
`endif
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
`ifndef BIU_ARB_FIXED_PRIO_EN
      rr_ptr_q <= rr_ptr_d;
`endif
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    id_fifo_q <= id_fifo_d;
  end

endmodule

// File: tb/tb_biu_bus_arbiter.sv
// Directed self-checking bench for biu_bus_arbiter with a small in-order memory model (2-cycle response latency).
// Honours BIU_ARB_FIXED_PRIO_EN for the re-lock priority expectation.
module tb_biu_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  req_lock = '0, req_vld = '0, rsp_rdy = 3'b111;
  logic [95:0] req_addr = '0;
  logic [2:0]  req_rdy, rsp_vld;
  logic [31:0] rsp_addr, rsp_data, mem_addr;
  logic        mem_vld, mem_rdy = 1'b1, mem_rsp_rdy, busy;
  logic        mem_rsp_vld = 1'b0;
  logic [31:0] mem_rsp_addr = '0, mem_rsp_data = '0;
  logic [1:0]  owner;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic memHold = 1'b0;
  logic memFlush = 1'b0;
  logic [31:0] mqAddr[$];
  int          mqTime[$];

  biu_bus_arbiter dut (
    .clk(clk), .rst(rst),
    .req_lock(req_lock), .req_vld(req_vld), .req_addr(req_addr), .req_rdy(req_rdy),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_addr(rsp_addr), .rsp_data(rsp_data),
    .mem_vld(mem_vld), .mem_rdy(mem_rdy), .mem_addr(mem_addr),
    .mem_rsp_vld(mem_rsp_vld), .mem_rsp_rdy(mem_rsp_rdy),
    .mem_rsp_addr(mem_rsp_addr), .mem_rsp_data(mem_rsp_data),
    .owner(owner), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memData(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  // Memory model: drives the response 2 ps after the edge, once the head read has aged 2 cycles.
  always begin
    @(posedge clk);
    cyc++;
    #2;
    if (memFlush) begin
      mqAddr.delete();
      mqTime.delete();
    end
    if (!memHold && mqAddr.size() > 0 && (cyc - mqTime[0]) >= 2) begin
      mem_rsp_vld  = 1'b1;
      mem_rsp_addr = mqAddr[0];
      mem_rsp_data = memData(mqAddr[0]);
    end else begin
      mem_rsp_vld  = 1'b0;
      mem_rsp_addr = '0;
      mem_rsp_data = '0;
    end
  end

  // Handshakes are observed mid-cycle, well away from the clock edge.
  always @(negedge clk) begin
    if (mem_rsp_vld && mem_rsp_rdy && mqAddr.size() > 0) begin
      void'(mqAddr.pop_front());
      void'(mqTime.pop_front());
    end
    if (mem_vld && mem_rdy) begin
      mqAddr.push_back(mem_addr);
      mqTime.push_back(cyc);
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    #3;
  endtask

  task automatic applyStimulus(input logic [2:0] lock, input logic [2:0] vld,
                               input logic [2:0] rrdy, input logic mrdy);
    req_lock = lock;
    req_vld  = vld;
    rsp_rdy  = rrdy;
    mem_rdy  = mrdy;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic doReset();
    rst      = 1'b1;
    memFlush = 1'b1;
    applyStimulus(3'b000, 3'b000, 3'b111, 1'b1);
    nextCycle();
    nextCycle();
    rst      = 1'b0;
    memFlush = 1'b0;
  endtask

  initial begin
    int issued, received, hs, hs2, rx, i0, i1, k;
    logic [31:0] expA;
    logic [1:0]  expOwner;

    // Reset state
    req_addr = {32'h0, 32'h0, 32'hABCD_0000};
    doReset();
    sample();
    checkOutput("rst_owner", owner, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_mem_vld", mem_vld, 0);
    checkOutput("rst_req_rdy", req_rdy, 0);
    checkOutput("rst_rsp_vld", rsp_vld, 0);
    checkOutput("rst_mem_rsp_rdy", mem_rsp_rdy, 0);
    checkOutput("rst_mem_addr", mem_addr, 32'hABCD_0000);
    nextCycle();

    // Test 1: single BIU, 144-read streaming burst
    $display("[TB] test 1: BIU0 144-read burst");
    issued = 0;
    received = 0;
    for (int c = 0; c < 400 && received < 144; c++) begin
      applyStimulus(3'b001, (issued < 144) ? 3'b001 : 3'b000, 3'b111, 1'b1);
      expA = 32'h1000 + 32'(4 * issued);
      req_addr[31:0] = expA;
      sample();
      if (c == 0) begin
        checkOutput("t1_arb_mem_vld", mem_vld, 0);
        checkOutput("t1_arb_owner", owner, 0);
      end else if (issued < 144) begin
        checkOutput("t1_mem_vld", mem_vld, 1);
        checkOutput("t1_mem_addr", mem_addr, expA);
      end
      if (rsp_vld != 3'b000) begin
        expA = 32'h1000 + 32'(4 * received);
        checkOutput("t1_rsp_vld", rsp_vld, 3'b001);
        checkOutput("t1_rsp_addr", rsp_addr, expA);
        checkOutput("t1_rsp_data", rsp_data, memData(expA));
        received++;
      end
      if (mem_vld && mem_rdy) issued++;
      nextCycle();
    end
    checkOutput("t1_issued", issued, 144);
    checkOutput("t1_received", received, 144);

    // Test 2: simultaneous lock, 2-cycle regrant, re-lock priority
    $display("[TB] test 2: BIU0/BIU1 contention");
    doReset();
    applyStimulus(3'b011, 3'b000, 3'b111, 1'b1);
    sample();
    checkOutput("t2_arb_busy", busy, 0);
    checkOutput("t2_arb_req_rdy", req_rdy, 3'b000);
    nextCycle();
    sample();
    checkOutput("t2_owner0", owner, 0);
    checkOutput("t2_owner0_req_rdy", req_rdy, 3'b001);
    checkOutput("t2_owner0_busy", busy, 1);
    nextCycle();
    applyStimulus(3'b010, 3'b000, 3'b111, 1'b1);
    sample();
    checkOutput("t2_release_req_rdy", req_rdy, 3'b000);
    checkOutput("t2_release_busy", busy, 1);
    nextCycle();
    applyStimulus(3'b011, 3'b000, 3'b111, 1'b1);
    sample();
    checkOutput("t2_idle_busy", busy, 0);
    checkOutput("t2_idle_req_rdy", req_rdy, 3'b000);
    nextCycle();
    sample();
`ifdef BIU_ARB_FIXED_PRIO_EN
    expOwner = 2'd0;
`else
    expOwner = 2'd1;
`endif
    checkOutput("t2_regrant_owner", owner, expOwner);
    checkOutput("t2_regrant_req_rdy", req_rdy, 3'b001 << expOwner);
    checkOutput("t2_regrant_busy", busy, 1);
    nextCycle();

    // Test 3: outstanding limit
    $display("[TB] test 3: outstanding limit");
    doReset();
    memHold = 1'b1;
    hs = 0;
    for (int c = 0; c < 12; c++) begin
      applyStimulus(3'b100, 3'b100, 3'b111, 1'b1);
      req_addr[95:64] = 32'h2000 + 32'(4 * hs);
      sample();
      if (mem_vld && mem_rdy) hs++;
      if (c == 11) begin
        checkOutput("t3_full_req_rdy", req_rdy, 3'b000);
        checkOutput("t3_full_mem_vld", mem_vld, 0);
      end
      nextCycle();
    end
    checkOutput("t3_handshakes", hs, 8);
    memHold = 1'b0;
    sample();
    checkOutput("t3_pop_rsp_vld", rsp_vld, 3'b100);
    checkOutput("t3_pop_mem_rsp_rdy", mem_rsp_rdy, 1);
    checkOutput("t3_pop_rsp_addr", rsp_addr, 32'h2000);
    checkOutput("t3_pop_push_blocked", req_rdy, 3'b000);
    nextCycle();
    memHold = 1'b1;
    hs2 = 0;
    for (int c = 0; c < 4; c++) begin
      req_addr[95:64] = 32'h2000 + 32'(4 * (hs + hs2));
      sample();
      if (c == 0) checkOutput("t3_refill_req_rdy", req_rdy, 3'b100);
      if (mem_vld && mem_rdy) hs2++;
      nextCycle();
    end
    checkOutput("t3_refill_handshakes", hs2, 1);
    applyStimulus(3'b000, 3'b000, 3'b111, 1'b1);
    memHold = 1'b0;
    rx = 0;
    for (int c = 0; c < 20; c++) begin
      sample();
      if (mem_rsp_vld && mem_rsp_rdy) begin
        checkOutput("t3_drain_addr", rsp_addr, 32'h2000 + 32'(4 * (rx + 1)));
        rx++;
      end
      nextCycle();
    end
    checkOutput("t3_drain_count", rx, 8);
    sample();
    checkOutput("t3_drain_busy", busy, 0);
    nextCycle();

    // Test 4: response routing across an ownership change
    $display("[TB] test 4: routing across owners");
    doReset();
    memHold = 1'b1;
    i0 = 0;
    i1 = 0;
    for (int c = 0; c < 30 && i1 < 4; c++) begin
      applyStimulus({1'b0, 1'b1, i0 < 4}, {1'b0, i1 < 4, i0 < 4}, 3'b111, 1'b1);
      req_addr[31:0]  = 32'h3000 + 32'(4 * i0);
      req_addr[63:32] = 32'h4000 + 32'(4 * i1);
      sample();
      if (req_rdy[0] && req_vld[0]) i0++;
      if (req_rdy[1] && req_vld[1]) i1++;
      nextCycle();
    end
    checkOutput("t4_biu0_reads", i0, 4);
    checkOutput("t4_biu1_reads", i1, 4);
    applyStimulus(3'b000, 3'b000, 3'b111, 1'b1);
    memHold = 1'b0;
    k = 0;
    for (int c = 0; c < 40 && k < 8; c++) begin
      sample();
      if (mem_rsp_vld) begin
        expA = (k < 4) ? 32'h3000 + 32'(4 * k) : 32'h4000 + 32'(4 * (k - 4));
        checkOutput("t4_rsp_vld", rsp_vld, (k < 4) ? 3'b001 : 3'b010);
        checkOutput("t4_rsp_addr", rsp_addr, expA);
        k++;
      end
      nextCycle();
    end
    checkOutput("t4_rsp_count", k, 8);

    // Test 5: response backpressure
    $display("[TB] test 5: response backpressure");
    doReset();
    memHold = 1'b1;
    i0 = 0;
    for (int c = 0; c < 10 && i0 < 2; c++) begin
      applyStimulus(3'b001, 3'b001, 3'b111, 1'b1);
      req_addr[31:0] = 32'h5000 + 32'(4 * i0);
      sample();
      if (req_rdy[0] && req_vld[0]) i0++;
      nextCycle();
    end
    checkOutput("t5_reads", i0, 2);
    applyStimulus(3'b000, 3'b000, 3'b110, 1'b1);
    memHold = 1'b0;
    for (int c = 0; c < 3; c++) begin
      sample();
      checkOutput("t5_stall_mem_rsp_rdy", mem_rsp_rdy, 0);
      checkOutput("t5_stall_rsp_vld", rsp_vld, 3'b001);
      checkOutput("t5_stall_head_addr", rsp_addr, 32'h5000);
      nextCycle();
    end
    applyStimulus(3'b000, 3'b000, 3'b111, 1'b1);
    k = 0;
    for (int c = 0; c < 8; c++) begin
      sample();
      if (mem_rsp_vld && mem_rsp_rdy) begin
        expA = 32'h5000 + 32'(4 * k);
        checkOutput("t5_drain_addr", rsp_addr, expA);
        checkOutput("t5_drain_data", rsp_data, memData(expA));
        k++;
      end
      nextCycle();
    end
    checkOutput("t5_drain_count", k, 2);

    // Test 6: reset mid-burst with reads outstanding
    $display("[TB] test 6: reset mid-burst");
    doReset();
    memHold = 1'b1;
    i0 = 0;
    for (int c = 0; c < 10 && i0 < 3; c++) begin
      applyStimulus(3'b001, 3'b001, 3'b111, 1'b1);
      req_addr[31:0] = 32'h6000 + 32'(4 * i0);
      sample();
      if (req_rdy[0] && req_vld[0]) i0++;
      nextCycle();
    end
    checkOutput("t6_reads", i0, 3);
    rst = 1'b1;
    applyStimulus(3'b001, 3'b000, 3'b111, 1'b1);
    sample();
    checkOutput("t6_pre_busy", busy, 1);
    nextCycle();
    rst = 1'b0;
    memHold = 1'b0;
    sample();
    checkOutput("t6_busy", busy, 0);
    checkOutput("t6_req_rdy", req_rdy, 3'b000);
    checkOutput("t6_rsp_vld", rsp_vld, 3'b000);
    checkOutput("t6_mem_vld", mem_vld, 0);
    checkOutput("t6_stall_mem_rsp_rdy", mem_rsp_rdy, 0);
    nextCycle();
    applyStimulus(3'b000, 3'b000, 3'b111, 1'b1);
    memFlush = 1'b1;
    nextCycle();
    nextCycle();
    memFlush = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
